cla_addsub_pipe: RTL

- Parametrised, pipelined carry-lookahead adder/subtractor for the ToyALU datapath.
- Successor to the fixed 32-bit combinational CLA. Adds width, group and pipeline-depth parameters, a subtract mode, carry-in and status flags.
- Splits the operand into STAGES bit-slices. Each pipeline stage resolves one slice with two-level lookahead and passes its registered carry to the next stage.
- Valid/ready handshake on both sides, with full backpressure.

---
 rtl/alu_pkg.sv | 19 +
 rtl/cla_group.sv | 50 +++++
 rtl/cla_addsub_pipe.sv | 137 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ToyALU datapath definitions: default adder geometry, op encoding
// and the per-stage control payload that travels with each beat.
package alu_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_GROUP  = 4;
    localparam int DEF_STAGES = 2;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Operand slices and partial sums are width-dependent and live in packed
    // arrays in the adder; only the width-independent bits are bundled here.
    typedef struct packed {
        logic valid;
        logic carry;
    } stage_ctl_t;

endpackage

// File: rtl/cla_group.sv
// GROUP-bit carry-lookahead block: sum bits from a group carry-in, plus the
// group generate/propagate for the next lookahead level.
module cla_group #(
    parameter int GROUP = 4
) (
    input  logic [GROUP-1:0] i_x,
    input  logic [GROUP-1:0] i_y,
    input  logic             i_c0,
    output logic [GROUP-1:0] o_s,
    output logic             o_g,
    output logic             o_p
);

    logic [GROUP-1:0] w_gen;
    logic [GROUP-1:0] w_prop;
    logic [GROUP-1:0] w_c;

    assign w_gen  = i_x & i_y;
    assign w_prop = i_x ^ i_y;

    // Each bit carry is a flat sum of products, not a ripple chain.
    always_comb begin : bit_carries
        logic t, pp;
        w_c = '0;
        for (int i = 0; i < GROUP; i++) begin
            t  = 1'b0;
            pp = 1'b1;
            for (int j = i - 1; j >= 0; j--) begin
                t  = t | (pp & w_gen[j]);
                pp = pp & w_prop[j];
            end
            w_c[i] = t | (pp & i_c0);
        end
    end

    // Kept apart from the carry block so G/P never appear to depend on i_c0.
    always_comb begin : group_gen
        logic pp;
        o_g = 1'b0;
        pp  = 1'b1;
        for (int j = GROUP - 1; j >= 0; j--) begin
            o_g = o_g | (pp & w_gen[j]);
            pp  = pp & w_prop[j];
        end
    end

    assign o_p = &w_prop;
    assign o_s = w_prop ^ w_c;

endmodule

// File: rtl/cla_addsub_pipe.sv
// Pipelined two-level carry-lookahead adder/subtractor. Stage k resolves
// operand slice k and hands its registered carry to stage k+1.
module cla_addsub_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int GROUP  = DEF_GROUP,
    parameter int STAGES = DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int SW   = WIDTH / STAGES;
    localparam int NG   = SW / GROUP;
    localparam int LAST = STAGES - 1;

    if (WIDTH % (STAGES * GROUP) != 0) begin : g_bad_param
        $error("cla_addsub_pipe: WIDTH must be a multiple of STAGES*GROUP");
    end

    stage_ctl_t [STAGES-1:0]            r_ctl;
    logic       [STAGES-1:0][WIDTH-1:0] r_a;
    logic       [STAGES-1:0][WIDTH-1:0] r_bx;
    logic       [STAGES-1:0][WIDTH-1:0] r_sum;
    logic                               r_ovf;
    logic                               r_zero;

    logic       [STAGES-1:0][WIDTH-1:0] w_a;
    logic       [STAGES-1:0][WIDTH-1:0] w_bx;
    logic       [STAGES-1:0][WIDTH-1:0] w_sp;
    logic       [STAGES-1:0][WIDTH-1:0] w_so;
    logic       [STAGES-1:0]            w_vin;
    logic       [STAGES-1:0]            w_cin;
    logic       [STAGES-1:0]            w_cout;
    logic                               w_en;
    logic                               w_unused;

    // One global stall: the whole pipe freezes while the output is held.
    assign w_en     = !r_ctl[LAST].valid || out_ready;
    assign in_ready = w_en;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [NG-1:0] w_gg;
        logic [NG-1:0] w_gp;
        logic [NG:0]   w_gc;
        logic [SW-1:0] w_ss;

        if (k == 0) begin : g_first
            assign w_a[k]   = a;
            assign w_bx[k]  = b ^ {WIDTH{sub == OP_SUB}};
            assign w_cin[k] = cin ^ (sub == OP_SUB);
            assign w_sp[k]  = '0;
            assign w_vin[k] = in_valid;
        end else begin : g_next
            assign w_a[k]   = r_a[k-1];
            assign w_bx[k]  = r_bx[k-1];
            assign w_cin[k] = r_ctl[k-1].carry;
            assign w_sp[k]  = r_sum[k-1];
            assign w_vin[k] = r_ctl[k-1].valid;
        end

        for (genvar g = 0; g < NG; g++) begin : g_grp
            cla_group #(.GROUP(GROUP)) u_grp (
                .i_x  (w_a[k][k*SW + g*GROUP +: GROUP]),
                .i_y  (w_bx[k][k*SW + g*GROUP +: GROUP]),
                .i_c0 (w_gc[g]),
                .o_s  (w_ss[g*GROUP +: GROUP]),
                .o_g  (w_gg[g]),
                .o_p  (w_gp[g])
            );
        end

        // Second lookahead level: every group carry straight from slice carry-in.
        always_comb begin : grp_carries
            logic t, pp;
            w_gc = '0;
            for (int i = 0; i <= NG; i++) begin
                t  = 1'b0;
                pp = 1'b1;
                for (int j = i - 1; j >= 0; j--) begin
                    t  = t | (pp & w_gg[j]);
                    pp = pp & w_gp[j];
                end
                w_gc[i] = t | (pp & w_cin[k]);
            end
        end

        assign w_cout[k] = w_gc[NG];
        // Upper slices of the partial sum are still zero, so OR inserts the slice.
        assign w_so[k]   = w_sp[k] | (WIDTH'(w_ss) << (k * SW));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctl  <= '0;
            r_a    <= '0;
            r_bx   <= '0;
            r_sum  <= '0;
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
        end else if (w_en) begin
            for (int k = 0; k < STAGES; k++) begin
                r_ctl[k].valid <= w_vin[k];
                r_ctl[k].carry <= w_cout[k];
                r_a[k]         <= w_a[k];
                r_bx[k]        <= w_bx[k];
                r_sum[k]       <= w_so[k];
            end
            r_ovf  <= (w_a[LAST][WIDTH-1] == w_bx[LAST][WIDTH-1]) &&
                      (w_so[LAST][WIDTH-1] != w_a[LAST][WIDTH-1]);
            r_zero <= (w_so[LAST] == '0);
        end
    end

    // Operands are fully consumed by the last stage; its copies go nowhere.
    assign w_unused = ^{r_a[LAST], r_bx[LAST]};

    assign out_valid = r_ctl[LAST].valid;
    assign sum       = r_sum[LAST];
    assign cout      = r_ctl[LAST].carry;
    assign ovf       = r_ovf;
    assign zero      = r_zero;

endmodule
